chirp_sweep_ctrl: RTL and testbench
===================================

// Module: chirp_sweep_ctrl
// PURPOSE
//  Chirp frequency-sweep controller; sits directly upstream of the phase accumulator and drives its ftw input.
//  Produces a per-cycle linear FTW ramp (up, down or triangle) from a latched start word, step and step count.
//  Supports one-shot or continuous sweeps, with a sweep-start sync pulse and a done pulse for the host/sequencer.
// PARAMETERS
//  N      32  FTW width; must match the downstream phase accumulator
//  CNT_W  24  width of step counter / num_steps
// PORTS
//  clk        in   1      system clock; all state on rising edge
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      1-cycle request to begin a sweep; honoured only in IDLE
//  abort      in   1      stop the sweep immediately; wins over start
//  mode       in   2      00 up, 01 down, 10 triangle, 11 treated as up
//  cont       in   1      1 = restart the sweep endlessly until abort
//  ftw_start  in   N      FTW at k=0
//  ftw_step   in   N      FTW increment per cycle (unsigned)
//  num_steps  in   CNT_W  steps per leg
//  ftw        out  N      FTW to phase accumulator; 0 when idle
//  busy       out  1      1 while in a sweep state
//  sweep_sync out  1      1-cycle pulse on the first cycle of every sweep (k=0)
//  done       out  1      1-cycle pulse on the first IDLE cycle after a natural (non-abort) end
// BEHAVIOUR
//  Reset: state=IDLE; ftw=0, busy=0, sweep_sync=0, done=0; counter and latched params cleared.
//  mode, cont, ftw_start, ftw_step and num_steps are latched on accepted start. Inputs changing mid-sweep have no effect.
//  States: IDLE, UP, DOWN.
//  IDLE:
//   - start=1 and abort=0 -> next cycle enters UP (mode 00/10/11) or DOWN (mode 01).
//   - In that entry cycle: ftw=ftw_start, k=0, busy=1, sweep_sync=1.
//   - Latency is 1 clock.
//  UP leg: output ftw_start + k*ftw_step. Realise as ftw <= ftw + step; no multiplier.
//  DOWN leg: output ftw_start - k*ftw_step (mode 01). For the triangle return, output continues downward from the peak.
//  All arithmetic is mod 2^N; wrap is silent (no saturation).
//  Up/down modes:
//   - The leg outputs k=0..num_steps, i.e. num_steps+1 cycles.
//   - Triangle: UP k=0..num_steps, then DOWN k=num_steps-1..1, i.e. 2*num_steps cycles.
//   - Triangle with num_steps=0: 1 cycle (k=0 only).
//   - Triangle with num_steps=1: 2 cycles (k=0, k=1), no DOWN cycles.
//  End of sweep:
//   - cont=1: next cycle restarts at k=0 (ftw=ftw_start, sweep_sync=1); no gap, busy stays 1, no done.
//   - cont=0: next cycle IDLE, ftw=0, busy=0, done=1 for one cycle.
//  abort=1 in any state: next cycle IDLE, ftw=0, busy=0, done=0, sweep_sync=0.
//  start while busy: ignored (not queued).
//  Reset mid-sweep: outputs go to reset values immediately (async); the sweep is lost.
//  All outputs are registered; no combinational path from inputs to outputs.
// TESTING
//  1. Up ramp: start=100, step=10, num_steps=3, mode=00, cont=0.
//     -> ftw 100,110,120,130 on cycles 1-4 after start; sync on cycle 1; done+ftw=0 on cycle 5; busy high cycles 1-4.
//  2. Triangle: same params, mode=10.
//     -> 100,110,120,130,120,110, then IDLE with done.
//     With cont=1 -> 110 is followed directly by 100 with sync; done never asserts.
//  3. Wrap: start=0xFFFF_FFF0, step=0x10, num_steps=2, mode=00.
//     -> 0xFFFF_FFF0, 0x0000_0000, 0x0000_0010.
//     Down mode with start=5, step=10, num_steps=1 -> 5, 0xFFFF_FFFB.
//  4. Abort/start precedence:
//     - abort on 2nd sweep cycle -> ftw=0, busy=0 next cycle, no done.
//     - start+abort together in IDLE -> stays IDLE.
//     - start pulses mid-sweep -> sequence unchanged.
//  5. Edges and reset:
//     - num_steps=0 up -> single cycle ftw=start, then done.
//     - Async rst asserted mid-sweep (between edges) -> all outputs 0 immediately.
//     - After rst release, a new start behaves as in test 1.

Source files
------------

// File: rtl/chirp_sweep_ctrl.sv
// Chirp frequency-sweep controller.
// Drives the phase accumulator's frequency tuning word with a linear ramp.
// The ramp can run up, down or as a triangle, either once or continuously.
// All sweep parameters are captured when a sweep is accepted, so the host
// may change its inputs freely while a sweep is running.
module chirp_sweep_ctrl #(
   parameter int N     = 32,
   parameter int CNT_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [1:0]       i_mode,
   input  logic             i_cont,
   input  logic [N-1:0]     i_ftw_start,
   input  logic [N-1:0]     i_ftw_step,
   input  logic [CNT_W-1:0] i_num_steps,
   output logic [N-1:0]     o_ftw,
   output logic             o_busy,
   output logic             o_sweep_sync,
   output logic             o_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_stateNext;
   logic [CNT_W-1:0] r_k;
   logic [CNT_W-1:0] w_kNext;
   logic [N-1:0]     r_ftw;
   logic [N-1:0]     w_ftwNext;
   logic             r_busy;
   logic             w_busyNext;
   logic             r_sync;
   logic             w_syncNext;
   logic             r_done;
   logic             w_doneNext;
   logic             w_sweepEnd;

   logic [1:0]       r_mode;
   logic             r_cont;
   logic [N-1:0]     r_ftwStart;
   logic [N-1:0]     r_ftwStep;
   logic [CNT_W-1:0] r_numSteps;

   logic             w_accept;
   logic             w_triangle;
   logic             w_downMode;

   // A start is only taken from IDLE, and abort always vetoes it.
   assign w_accept   = (r_state == IDLE) && i_start && !i_abort;
   // Mode 11 is deliberately neither of these, so it behaves as a plain up ramp.
   assign w_triangle = (r_mode == 2'b10);
   assign w_downMode = (r_mode == 2'b01);

   // Capture the sweep parameters at the moment a sweep is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mode     <= 2'b00;
         r_cont     <= 1'b0;
         r_ftwStart <= '0;
         r_ftwStep  <= '0;
         r_numSteps <= '0;
      end else if (w_accept) begin
         r_mode     <= i_mode;
         r_cont     <= i_cont;
         r_ftwStart <= i_ftw_start;
         r_ftwStep  <= i_ftw_step;
         r_numSteps <= i_num_steps;
      end
   end

   // Next-state and next-output logic. The outputs are computed one cycle
   // ahead and then registered, so no input reaches an output combinationally.
   // The ramp is built incrementally (add or subtract the step each cycle),
   // which keeps the datapath to a single adder/subtractor.
   always_comb begin
      w_stateNext = r_state;
      w_kNext     = r_k;
      w_ftwNext   = r_ftw;
      w_busyNext  = r_busy;
      w_syncNext  = 1'b0;
      w_doneNext  = 1'b0;
      w_sweepEnd  = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_stateNext = (i_mode == 2'b01) ? DOWN : UP;
               w_kNext     = '0;
               w_ftwNext   = i_ftw_start;
               w_busyNext  = 1'b1;
               w_syncNext  = 1'b1;
            end
         end
         UP: begin
            if (r_k != r_numSteps) begin
               w_kNext   = r_k + CNT_W'(1);
               w_ftwNext = r_ftw + r_ftwStep;
            end else if (w_triangle && (r_numSteps > CNT_W'(1))) begin
               // The return leg starts one step below the peak, so the peak is
               // not repeated.
               w_stateNext = DOWN;
               w_kNext     = r_numSteps - CNT_W'(1);
               w_ftwNext   = r_ftw - r_ftwStep;
            end else begin
               w_sweepEnd = 1'b1;
            end
         end
         DOWN: begin
            if (w_downMode) begin
               if (r_k != r_numSteps) begin
                  w_kNext   = r_k + CNT_W'(1);
                  w_ftwNext = r_ftw - r_ftwStep;
               end else begin
                  w_sweepEnd = 1'b1;
               end
            end else begin
               // Triangle return leg counts k back down and stops at k=1, so
               // a continuous triangle flows straight into the next k=0.
               if (r_k > CNT_W'(1)) begin
                  w_kNext   = r_k - CNT_W'(1);
                  w_ftwNext = r_ftw - r_ftwStep;
               end else begin
                  w_sweepEnd = 1'b1;
               end
            end
         end
         default: begin
            w_stateNext = IDLE;
            w_kNext     = '0;
            w_ftwNext   = '0;
            w_busyNext  = 1'b0;
         end
      endcase

      if (w_sweepEnd) begin
         if (r_cont) begin
            w_stateNext = w_downMode ? DOWN : UP;
            w_kNext     = '0;
            w_ftwNext   = r_ftwStart;
            w_busyNext  = 1'b1;
            w_syncNext  = 1'b1;
         end else begin
            w_stateNext = IDLE;
            w_kNext     = '0;
            w_ftwNext   = '0;
            w_busyNext  = 1'b0;
            w_doneNext  = 1'b1;
         end
      end

      // Abort overrides everything, including a natural end, and never
      // produces a done pulse.
      if (i_abort) begin
         w_stateNext = IDLE;
         w_kNext     = '0;
         w_ftwNext   = '0;
         w_busyNext  = 1'b0;
         w_syncNext  = 1'b0;
         w_doneNext  = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_k     <= '0;
         r_ftw   <= '0;
         r_busy  <= 1'b0;
         r_sync  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         r_k     <= w_kNext;
         r_ftw   <= w_ftwNext;
         r_busy  <= w_busyNext;
         r_sync  <= w_syncNext;
         r_done  <= w_doneNext;
      end
   end

   assign o_ftw        = r_ftw;
   assign o_busy       = r_busy;
   assign o_sweep_sync = r_sync;
   assign o_done       = r_done;

endmodule

// File: tb/tb_chirp_sweep_ctrl.sv
// Testbench for chirp_sweep_ctrl.
// A sequence-level model expands each accepted sweep into its full list of
// FTW values and is compared with the DUT on every falling edge. Directed
// literal expectations pin the model to hand-computed values.
module tb_chirp_sweep_ctrl;

   logic        clk;
   logic        rst;
   logic        i_start;
   logic        i_abort;
   logic [1:0]  i_mode;
   logic        i_cont;
   logic [31:0] i_ftw_start;
   logic [31:0] i_ftw_step;
   logic [23:0] i_num_steps;
   logic [31:0] o_ftw;
   logic        o_busy;
   logic        o_sweep_sync;
   logic        o_done;

   int checks = 0;
   int errors = 0;

   logic [31:0] seq[$];
   int          pos;
   logic        mActive;
   logic        mCont;
   logic [31:0] expFtw;
   logic        expBusy;
   logic        expSync;
   logic        expDone;

   chirp_sweep_ctrl #(.N(32), .CNT_W(24)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_start      (i_start),
      .i_abort      (i_abort),
      .i_mode       (i_mode),
      .i_cont       (i_cont),
      .i_ftw_start  (i_ftw_start),
      .i_ftw_step   (i_ftw_step),
      .i_num_steps  (i_num_steps),
      .o_ftw        (o_ftw),
      .o_busy       (o_busy),
      .o_sweep_sync (o_sweep_sync),
      .o_done       (o_done)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it and reports a FAIL line on mismatch.
   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Sequence model: on an accepted start, list every FTW of one sweep period
   // as start +/- k*step, then step through the list one clock at a time.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         seq.delete();
         pos     = 0;
         mActive = 1'b0;
         mCont   = 1'b0;
         expFtw  = 32'd0;
         expBusy = 1'b0;
         expSync = 1'b0;
         expDone = 1'b0;
      end else begin
         expSync = 1'b0;
         expDone = 1'b0;
         if (mActive) begin
            if (i_abort) begin
               mActive = 1'b0;
               expFtw  = 32'd0;
               expBusy = 1'b0;
            end else if (pos + 1 < seq.size()) begin
               pos++;
               expFtw = seq[pos];
            end else if (mCont) begin
               pos     = 0;
               expFtw  = seq[0];
               expSync = 1'b1;
            end else begin
               mActive = 1'b0;
               expFtw  = 32'd0;
               expBusy = 1'b0;
               expDone = 1'b1;
            end
         end else if (i_start && !i_abort) begin
            seq.delete();
            if (i_mode == 2'b01) begin
               for (int k = 0; k <= int'(i_num_steps); k++)
                  seq.push_back(i_ftw_start - 32'(k) * i_ftw_step);
            end else begin
               for (int k = 0; k <= int'(i_num_steps); k++)
                  seq.push_back(i_ftw_start + 32'(k) * i_ftw_step);
               if (i_mode == 2'b10) begin
                  for (int k = int'(i_num_steps) - 1; k >= 1; k--)
                     seq.push_back(i_ftw_start + 32'(k) * i_ftw_step);
               end
            end
            mCont   = i_cont;
            pos     = 0;
            mActive = 1'b1;
            expFtw  = seq[0];
            expBusy = 1'b1;
            expSync = 1'b1;
         end
      end
   end

   // Compare the DUT with the model on every falling edge outside reset.
   always @(negedge clk) begin
      if (!rst) begin
         checkVal("model.ftw",  o_ftw,                 expFtw);
         checkVal("model.busy", {31'd0, o_busy},       {31'd0, expBusy});
         checkVal("model.sync", {31'd0, o_sweep_sync}, {31'd0, expSync});
         checkVal("model.done", {31'd0, o_done},       {31'd0, expDone});
      end
   end

   // Pulse start for one cycle with the given parameters; returns on the
   // falling edge of the first sweep cycle.
   task automatic applyStimulus(input logic [1:0] m, input logic c, input logic [31:0] s,
                                input logic [31:0] st, input logic [23:0] n);
      i_mode      = m;
      i_cont      = c;
      i_ftw_start = s;
      i_ftw_step  = st;
      i_num_steps = n;
      i_start     = 1'b1;
      @(negedge clk);
      i_start     = 1'b0;
   endtask

   // Check a hand-computed expectation for the current cycle, then advance.
   task automatic checkOutput(input string name, input logic [31:0] eFtw, input logic eBusy,
                              input logic eSync, input logic eDone);
      checkVal({name, ".ftw"},  o_ftw,                 eFtw);
      checkVal({name, ".busy"}, {31'd0, o_busy},       {31'd0, eBusy});
      checkVal({name, ".sync"}, {31'd0, o_sweep_sync}, {31'd0, eSync});
      checkVal({name, ".done"}, {31'd0, o_done},       {31'd0, eDone});
      @(negedge clk);
   endtask

   // Directed stimulus sequence.
   initial begin
      rst         = 1'b0;
      i_start     = 1'b0;
      i_abort     = 1'b0;
      i_mode      = 2'b00;
      i_cont      = 1'b0;
      i_ftw_start = 32'd0;
      i_ftw_step  = 32'd0;
      i_num_steps = 24'd0;
      #1 rst = 1'b1;
      @(negedge clk);
      checkVal("reset.ftw",  o_ftw,                 32'd0);
      checkVal("reset.busy", {31'd0, o_busy},       32'd0);
      checkVal("reset.sync", {31'd0, o_sweep_sync}, 32'd0);
      checkVal("reset.done", {31'd0, o_done},       32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Up ramp; parameters scrambled mid-sweep must not matter.
      applyStimulus(2'b00, 1'b0, 32'd100, 32'd10, 24'd3);
      i_ftw_start = 32'd7;
      i_ftw_step  = 32'd999;
      i_num_steps = 24'd50;
      i_mode      = 2'b01;
      checkOutput("up.c1", 32'd100, 1'b1, 1'b1, 1'b0);
      checkOutput("up.c2", 32'd110, 1'b1, 1'b0, 1'b0);
      checkOutput("up.c3", 32'd120, 1'b1, 1'b0, 1'b0);
      checkOutput("up.c4", 32'd130, 1'b1, 1'b0, 1'b0);
      checkOutput("up.c5", 32'd0,   1'b0, 1'b0, 1'b1);
      checkOutput("up.c6", 32'd0,   1'b0, 1'b0, 1'b0);

      // One-shot triangle.
      applyStimulus(2'b10, 1'b0, 32'd100, 32'd10, 24'd3);
      checkOutput("tri.c1", 32'd100, 1'b1, 1'b1, 1'b0);
      checkOutput("tri.c2", 32'd110, 1'b1, 1'b0, 1'b0);
      checkOutput("tri.c3", 32'd120, 1'b1, 1'b0, 1'b0);
      checkOutput("tri.c4", 32'd130, 1'b1, 1'b0, 1'b0);
      checkOutput("tri.c5", 32'd120, 1'b1, 1'b0, 1'b0);
      checkOutput("tri.c6", 32'd110, 1'b1, 1'b0, 1'b0);
      checkOutput("tri.c7", 32'd0,   1'b0, 1'b0, 1'b1);

      // Continuous triangle, stray start mid-sweep, then abort.
      applyStimulus(2'b10, 1'b1, 32'd100, 32'd10, 24'd3);
      checkOutput("ctri.c1", 32'd100, 1'b1, 1'b1, 1'b0);
      i_start = 1'b1;
      i_mode  = 2'b01;
      checkOutput("ctri.c2", 32'd110, 1'b1, 1'b0, 1'b0);
      i_start = 1'b0;
      checkOutput("ctri.c3", 32'd120, 1'b1, 1'b0, 1'b0);
      checkOutput("ctri.c4", 32'd130, 1'b1, 1'b0, 1'b0);
      checkOutput("ctri.c5", 32'd120, 1'b1, 1'b0, 1'b0);
      checkOutput("ctri.c6", 32'd110, 1'b1, 1'b0, 1'b0);
      checkOutput("ctri.c7", 32'd100, 1'b1, 1'b1, 1'b0);
      checkOutput("ctri.c8", 32'd110, 1'b1, 1'b0, 1'b0);
      repeat (8) @(negedge clk);
      i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
      checkOutput("ctri.abort", 32'd0, 1'b0, 1'b0, 1'b0);

      // Wrap-around up ramp.
      applyStimulus(2'b00, 1'b0, 32'hFFFF_FFF0, 32'h10, 24'd2);
      checkOutput("wrapup.c1", 32'hFFFF_FFF0, 1'b1, 1'b1, 1'b0);
      checkOutput("wrapup.c2", 32'h0000_0000, 1'b1, 1'b0, 1'b0);
      checkOutput("wrapup.c3", 32'h0000_0010, 1'b1, 1'b0, 1'b0);
      checkOutput("wrapup.c4", 32'd0,         1'b0, 1'b0, 1'b1);

      // Wrap-around down ramp.
      applyStimulus(2'b01, 1'b0, 32'd5, 32'd10, 24'd1);
      checkOutput("wrapdn.c1", 32'd5,         1'b1, 1'b1, 1'b0);
      checkOutput("wrapdn.c2", 32'hFFFF_FFFB, 1'b1, 1'b0, 1'b0);
      checkOutput("wrapdn.c3", 32'd0,         1'b0, 1'b0, 1'b1);

      // Abort on the second sweep cycle.
      applyStimulus(2'b00, 1'b0, 32'd100, 32'd10, 24'd3);
      checkOutput("abort.c1", 32'd100, 1'b1, 1'b1, 1'b0);
      i_abort = 1'b1;
      checkOutput("abort.c2", 32'd110, 1'b1, 1'b0, 1'b0);
      i_abort = 1'b0;
      checkOutput("abort.c3", 32'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("abort.c4", 32'd0, 1'b0, 1'b0, 1'b0);

      // Start together with abort in IDLE is refused.
      i_abort = 1'b1;
      applyStimulus(2'b00, 1'b0, 32'd100, 32'd10, 24'd3);
      i_abort = 1'b0;
      checkOutput("startabort.c1", 32'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("startabort.c2", 32'd0, 1'b0, 1'b0, 1'b0);

      // Single-cycle sweeps: up with zero steps, triangle with zero and one step.
      applyStimulus(2'b00, 1'b0, 32'd100, 32'd10, 24'd0);
      checkOutput("zero.c1", 32'd100, 1'b1, 1'b1, 1'b0);
      checkOutput("zero.c2", 32'd0,   1'b0, 1'b0, 1'b1);
      applyStimulus(2'b10, 1'b0, 32'd40, 32'd3, 24'd0);
      checkOutput("tri0.c1", 32'd40, 1'b1, 1'b1, 1'b0);
      checkOutput("tri0.c2", 32'd0,  1'b0, 1'b0, 1'b1);
      applyStimulus(2'b10, 1'b0, 32'd40, 32'd3, 24'd1);
      checkOutput("tri1.c1", 32'd40, 1'b1, 1'b1, 1'b0);
      checkOutput("tri1.c2", 32'd43, 1'b1, 1'b0, 1'b0);
      checkOutput("tri1.c3", 32'd0,  1'b0, 1'b0, 1'b1);

      // Mode 11 behaves as up, continuous restart checked by the model.
      applyStimulus(2'b11, 1'b1, 32'd1000, 32'd7, 24'd2);
      checkOutput("m11.c1", 32'd1000, 1'b1, 1'b1, 1'b0);
      checkOutput("m11.c2", 32'd1007, 1'b1, 1'b0, 1'b0);
      checkOutput("m11.c3", 32'd1014, 1'b1, 1'b0, 1'b0);
      checkOutput("m11.c4", 32'd1000, 1'b1, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a cycle.
      #2 rst = 1'b1;
      #1;
      checkVal("asyncrst.ftw",  o_ftw,                 32'd0);
      checkVal("asyncrst.busy", {31'd0, o_busy},       32'd0);
      checkVal("asyncrst.sync", {31'd0, o_sweep_sync}, 32'd0);
      checkVal("asyncrst.done", {31'd0, o_done},       32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("postrst.idle", 32'd0, 1'b0, 1'b0, 1'b0);

      // Fresh up ramp after reset.
      applyStimulus(2'b00, 1'b0, 32'd100, 32'd10, 24'd3);
      checkOutput("postrst.c1", 32'd100, 1'b1, 1'b1, 1'b0);
      checkOutput("postrst.c2", 32'd110, 1'b1, 1'b0, 1'b0);
      checkOutput("postrst.c3", 32'd120, 1'b1, 1'b0, 1'b0);
      checkOutput("postrst.c4", 32'd130, 1'b1, 1'b0, 1'b0);
      checkOutput("postrst.c5", 32'd0,   1'b0, 1'b0, 1'b1);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
